// File: rtl/dmem_responder.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// dmem_responder
//
// Single-port word-addressed data memory behind a three-state handshake FSM
// (IDLE -> WAIT -> RESP -> IDLE). Each request accepted in IDLE completes after
// WAIT_CYCLES wait states. ack is high for exactly one cycle per request,
// giving a latency of WAIT_CYCLES+1 from the accepting edge.
//
// Parameters
//   DEPTH        number of 32-bit words. Must be a power of two, 2..1024.
//   WAIT_CYCLES  wait states before the response. Must be 0..15.
//
// Ports
//   clk     in   single clock. All state updates on its rising edge.
//   reset   in   asynchronous, active-high reset. Clears the control state and
//                Dout. Does not clear the storage array.
//   req     in   request strobe. Only sampled while IDLE.
//   memWrt  in   1 = write, 0 = read.
//   addr    in   byte address. The word index is addr[log2(DEPTH)+1:2].
//   Din     in   write data.
//   Dout    out  registered read data. Holds the last read value.
//   ack     out  one-cycle completion pulse. It is high while in RESP.
//   busy    out  transaction in progress. It is high while in WAIT or RESP.
//   err     out  error flag, valid together with ack.
//
// Configuration
//   DMEM_ERR_CHECK_EN  When this macro is defined, the following requests are
//                      flagged:
//                        - misaligned requests (addr[1:0] != 0)
//                        - out-of-range requests (addr >= 4*DEPTH)
//                      A flagged request completes with the normal latency,
//                      suppresses the write, returns Dout=0 and raises err
//                      with ack.
//                      When the macro is undefined, err is always 0,
//                      addr[1:0] is ignored and the word index wraps
//                      modulo DEPTH.
// -----------------------------------------------------------------------------
module dmem_responder #(
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        memWrt,
  input  logic [31:0] addr,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        ack,
  output logic        busy,
  output logic        err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;

  // Request fields captured at acceptance so that the initiator is free to
  // change its outputs while the transaction sits in WAIT.
  logic        wrt_q;
  logic [31:0] addr_q;
  logic [31:0] din_q;

  logic        capture;   // accept a request in IDLE
  logic        access;    // perform the memory access on this edge
  logic        bad;       // request is flagged as an error
  logic        err_q;
  logic [31:0] dout_q;

  logic [31:0] mem [DEPTH];

  // ---------------------------------------------------------------------------
  // Access operand selection
  // ---------------------------------------------------------------------------
  // With zero wait states the access happens on the accepting edge itself.
  // That access uses the live inputs. Every later access uses the
  // captured copy.
  logic        use_live;
  logic        sel_wrt;
  logic [31:0] sel_addr;
  logic [31:0] sel_din;
  logic [IDX_W-1:0] idx;

  assign use_live = (state_q == ST_IDLE);
  assign sel_wrt  = use_live ? memWrt : wrt_q;
  assign sel_addr = use_live ? addr   : addr_q;
  assign sel_din  = use_live ? Din    : din_q;
  assign idx      = sel_addr[IDX_W+1:2];

`ifdef DMEM_ERR_CHECK_EN
  // A misaligned address is flagged.
  // Any set bit above the top word-index bit means addr >= 4*DEPTH.
  assign bad = (sel_addr[1:0] != 2'b00) || (sel_addr[31:IDX_W+2] != '0);
`else
  // The low byte bits and the bits above the index are ignored.
  // Ignoring the upper bits makes out-of-range addresses wrap
  // modulo DEPTH.
  assign bad = 1'b0;
  logic unused_addr_bits;
  assign unused_addr_bits = ^{sel_addr[31:IDX_W+2], sel_addr[1:0]};
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every output of this block gets a default first. This stops a
  // path through the case from leaving a signal unassigned and inferring a
  // latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    access  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req) begin
          capture = 1'b1;
          if (WAIT_CYCLES == 0) begin
            access  = 1'b1;
            state_d = ST_RESP;
          end else begin
            cnt_d   = 4'(WAIT_CYCLES);
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        // The counter saturates at zero. The <=1 test also releases the
        // FSM if the counter were ever found at zero.
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end
        if (cnt_q <= 4'd1) begin
          access  = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control state, captured request and registered outputs
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only. Every flop
  // then samples values from before the edge, whatever the block order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      wrt_q   <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
      err_q   <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture) begin
        wrt_q  <= memWrt;
        addr_q <= addr;
        din_q  <= Din;
      end
      // err lives only in RESP, so it is naturally qualified by ack.
      err_q <= access & bad;
      if (access) begin
        if (bad) begin
          dout_q <= '0;
        end else if (!sel_wrt) begin
          dout_q <= mem[idx];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Storage array
  // ---------------------------------------------------------------------------
  // NOTE: the storage array has no reset. Its contents survive reset, and
  // it can map onto plain RAM.
  // The write is gated by reset because the array does not see reset. Without
  // the gate, a zero-wait-state access could still land while reset is held.
  logic mem_we;
  assign mem_we = access & sel_wrt & ~bad & ~reset;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[idx] <= sel_din;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: ack and busy are decoded purely from the state register
  // ---------------------------------------------------------------------------
  assign ack  = (state_q == ST_RESP);
  assign busy = (state_q != ST_IDLE);
  assign err  = err_q;
  assign Dout = dout_q;

endmodule

// File: tb/tb_dmem_responder.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_dmem_responder
//
// Three responders with different geometries:
//   instance 0: DEPTH 64, WAIT_CYCLES 2
//   instance 1: DEPTH 16, WAIT_CYCLES 0
//   instance 2: DEPTH 64, WAIT_CYCLES 3
// A reference model holds one word array per instance. The model
// works on byte addresses with plain arithmetic:
//   word index = (addr / 4) mod DEPTH
//   error      = misaligned, or addr >= 4*DEPTH (only with the error-check
//                build)
// The expected ack/busy pattern follows from the latency rule alone.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

  localparam int NDUT = 3;
  localparam int DEPTHS [NDUT] = '{64, 16, 64};
  localparam int WCS    [NDUT] = '{2, 0, 3};

  logic        clk;
  logic        reset;
  logic        req_v   [NDUT];
  logic        wrt_v   [NDUT];
  logic [31:0] addr_v  [NDUT];
  logic [31:0] din_v   [NDUT];
  logic [31:0] dout_v  [NDUT];
  logic        ack_v   [NDUT];
  logic        busy_v  [NDUT];
  logic        err_v   [NDUT];

  int checks = 0;
  int errors = 0;

  logic [31:0] model_mem  [NDUT][1024];
  logic [31:0] model_dout [NDUT];

  dmem_responder #(.DEPTH(64), .WAIT_CYCLES(2)) u_dut0 (
    .clk(clk), .reset(reset), .req(req_v[0]), .memWrt(wrt_v[0]),
    .addr(addr_v[0]), .Din(din_v[0]), .Dout(dout_v[0]),
    .ack(ack_v[0]), .busy(busy_v[0]), .err(err_v[0])
  );

  dmem_responder #(.DEPTH(16), .WAIT_CYCLES(0)) u_dut1 (
    .clk(clk), .reset(reset), .req(req_v[1]), .memWrt(wrt_v[1]),
    .addr(addr_v[1]), .Din(din_v[1]), .Dout(dout_v[1]),
    .ack(ack_v[1]), .busy(busy_v[1]), .err(err_v[1])
  );

  dmem_responder #(.DEPTH(64), .WAIT_CYCLES(3)) u_dut2 (
    .clk(clk), .reset(reset), .req(req_v[2]), .memWrt(wrt_v[2]),
    .addr(addr_v[2]), .Din(din_v[2]), .Dout(dout_v[2]),
    .ack(ack_v[2]), .busy(busy_v[2]), .err(err_v[2])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Global time limit.
  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "time limit reached");
  end

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic int unsigned model_idx(input int d, input logic [31:0] a);
    return (a / 4) % DEPTHS[d];
  endfunction

  function automatic bit model_err(input int d, input logic [31:0] a);
`ifdef DMEM_ERR_CHECK_EN
    return (a % 4 != 0) || (longint'(a) >= 4 * longint'(DEPTHS[d]));
`else
    return 1'b0;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // One complete transaction on instance d, checked cycle by cycle.
  // The task expects:
  //   - ack in the cycle after edge N+WC, and nowhere earlier
  //   - busy throughout the transaction
  //   - Dout held through the wait cycles
  // The scramble flag changes the inputs right after acceptance.
  // ---------------------------------------------------------------------------
  task automatic txn(input int d, input logic w, input logic [31:0] a,
                     input logic [31:0] din, input bit scramble);
    int          wc;
    bit          e;
    logic [31:0] prev;
    wc   = WCS[d];
    e    = model_err(d, a);
    prev = model_dout[d];
    if (e) model_dout[d] = 32'h0;
    else if (w) model_mem[d][model_idx(d, a)] = din;
    else model_dout[d] = model_mem[d][model_idx(d, a)];

    @(negedge clk);
    req_v[d] = 1'b1; wrt_v[d] = w; addr_v[d] = a; din_v[d] = din;
    @(posedge clk);
    #1;
    req_v[d] = 1'b0;
    if (scramble) begin
      addr_v[d] = $urandom;
      din_v[d]  = $urandom;
      wrt_v[d]  = 1'($urandom_range(0, 1));
    end
    for (int j = 0; j <= wc; j++) begin
      @(negedge clk);
      check($sformatf("d%0d a%08h busy c%0d", d, a, j), 32'(busy_v[d]), 32'd1);
      check($sformatf("d%0d a%08h ack c%0d", d, a, j), 32'(ack_v[d]), 32'(j == wc));
      if (j == wc) begin
        check($sformatf("d%0d a%08h dout", d, a), dout_v[d], model_dout[d]);
        check($sformatf("d%0d a%08h err", d, a), 32'(err_v[d]), 32'(e));
      end else begin
        check($sformatf("d%0d a%08h dout hold c%0d", d, a, j), dout_v[d], prev);
      end
    end
    @(negedge clk);
    check($sformatf("d%0d a%08h ack after", d, a), 32'(ack_v[d]), 32'd0);
    check($sformatf("d%0d a%08h busy after", d, a), 32'(busy_v[d]), 32'd0);
  endtask

  // Reset pulse of n cycles. The outputs must clear at once, with no clock
  // edge needed.
  task automatic pulse_reset(input int n);
    @(negedge clk);
    reset = 1'b1;
    #1;
    for (int d = 0; d < NDUT; d++) begin
      check($sformatf("d%0d rst async busy", d), 32'(busy_v[d]), 32'd0);
      check($sformatf("d%0d rst async ack", d), 32'(ack_v[d]), 32'd0);
      check($sformatf("d%0d rst async dout", d), dout_v[d], 32'd0);
      check($sformatf("d%0d rst async err", d), 32'(err_v[d]), 32'd0);
      model_dout[d] = 32'h0;
    end
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      for (int d = 0; d < NDUT; d++) begin
        check($sformatf("d%0d rst held ack c%0d", d, c), 32'(ack_v[d]), 32'd0);
        check($sformatf("d%0d rst held busy c%0d", d, c), 32'(busy_v[d]), 32'd0);
      end
    end
    reset = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Directed and randomized sequence
  // ---------------------------------------------------------------------------
  initial begin
    reset = 1'b1;
    for (int d = 0; d < NDUT; d++) begin
      req_v[d] = 1'b0; wrt_v[d] = 1'b0; addr_v[d] = '0; din_v[d] = '0;
      model_dout[d] = 32'h0;
    end

    // Reset state
    repeat (3) @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      check($sformatf("d%0d reset dout", d), dout_v[d], 32'd0);
      check($sformatf("d%0d reset ack", d), 32'(ack_v[d]), 32'd0);
      check($sformatf("d%0d reset busy", d), 32'(busy_v[d]), 32'd0);
      check($sformatf("d%0d reset err", d), 32'(err_v[d]), 32'd0);
    end
    @(negedge clk);
    reset = 1'b0;

    // Fill every word so that every later read has a known value.
    // Word 0 of instance 1 is zero.
    for (int d = 0; d < NDUT; d++) begin
      for (int k = 0; k < DEPTHS[d]; k++) begin
        txn(d, 1'b1, 32'(k * 4), (d == 1 && k == 0) ? 32'h0 : $urandom, 1'b0);
      end
    end

    // Write, then read back: two wait states.
    txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
    txn(0, 1'b0, 32'h10, 32'h0, 1'b0);
    check("d0 readback DEADBEEF", model_dout[0], 32'hDEADBEEF);

    // Zero wait states: read word 0 after reset.
    pulse_reset(2);
    txn(1, 1'b0, 32'h0, 32'h0, 1'b0);

    // The captured request must survive inputs changing during WAIT.
    txn(2, 1'b1, 32'h40, 32'hA5A5_0F0F, 1'b1);
    txn(2, 1'b0, 32'h40, 32'h0, 1'b0);
    txn(0, 1'b1, 32'h24, 32'h0BAD_F00D, 1'b1);
    txn(0, 1'b0, 32'h24, 32'h0, 1'b0);

    // req held high: ack pulses spaced WC+2 apart.
    for (int d = 0; d < NDUT; d++) begin
      int          wc;
      int          win;
      logic [31:0] a;
      logic [31:0] prev;
      bit          exp_ack;
      wc   = WCS[d];
      win  = 3 * (wc + 2);
      a    = 32'($urandom_range(0, DEPTHS[d] - 1) * 4);
      prev = model_dout[d];
      @(negedge clk);
      req_v[d] = 1'b1; wrt_v[d] = 1'b0; addr_v[d] = a;
      for (int c = 0; c < win; c++) begin
        @(negedge clk);
        exp_ack = (c >= wc) && ((c - wc) % (wc + 2) == 0);
        check($sformatf("d%0d hold ack c%0d", d, c), 32'(ack_v[d]), 32'(exp_ack));
        check($sformatf("d%0d hold dout c%0d", d, c), dout_v[d],
              (c >= wc) ? model_mem[d][model_idx(d, a)] : prev);
      end
      req_v[d] = 1'b0;
      model_dout[d] = model_mem[d][model_idx(d, a)];
      @(negedge clk);
      check($sformatf("d%0d hold idle busy", d), 32'(busy_v[d]), 32'd0);
    end

    // Reset in the middle of WAIT drops the pending write.
    for (int d = 0; d < NDUT; d += 2) begin
      @(negedge clk);
      req_v[d] = 1'b1; wrt_v[d] = 1'b1; addr_v[d] = 32'h20; din_v[d] = 32'h12345678;
      @(posedge clk);
      #1;
      req_v[d] = 1'b0;
      pulse_reset(3);
      txn(d, 1'b0, 32'h20, 32'h0, 1'b0);
    end

    // Boundary addresses: misaligned, exactly 4*DEPTH, and far out of range.
    for (int d = 0; d < NDUT; d++) begin
      txn(d, 1'b1, 32'h13, $urandom, 1'b0);
      txn(d, 1'b1, 32'(4 * DEPTHS[d]), $urandom, 1'b0);
      txn(d, 1'b0, 32'h0, 32'h0, 1'b0);
      txn(d, 1'b0, 32'h10, 32'h0, 1'b0);
      txn(d, 1'b0, 32'h13, 32'h0, 1'b0);
      txn(d, 1'b0, 32'h0, 32'h0, 1'b0);
      txn(d, 1'b0, 32'hFFFF_FFFC, 32'h0, 1'b0);
    end

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      for (int d = 0; d < NDUT; d++) begin
        logic [31:0] a;
        if ($urandom_range(0, 3) != 0) a = 32'($urandom_range(0, DEPTHS[d] - 1) * 4);
        else a = $urandom;
        txn(d, 1'($urandom_range(0, 1)), a, $urandom, 1'($urandom_range(0, 1)));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
